// File: rtl/alu_rs.sv
// Eight-entry ALU reservation station: tag-indexed dispatch, dual-CDB wakeup, lowest-index issue.
// Optional macro ALU_RS_BYPASS_EN captures a CDB broadcast that coincides with dispatch.
module alu_rs (
  input  logic        clk,
  input  logic        rst,
  input  logic        ALUen,
  input  logic [31:0] ALUoperandO,
  input  logic [31:0] ALUoperandT,
  input  logic [4:0]  ALUtagO,
  input  logic [4:0]  ALUtagT,
  input  logic [4:0]  ALUtagW,
  input  logic [4:0]  ALUnameW,
  input  logic [4:0]  ALUop,
  input  logic [31:0] ALUaddr,
  input  logic        cdbAluEn,
  input  logic [4:0]  cdbAluTag,
  input  logic [31:0] cdbAluData,
  input  logic        cdbLsEn,
  input  logic [4:0]  cdbLsTag,
  input  logic [31:0] cdbLsData,
  output logic [3:0]  ALUfreeTag,
  output logic        rsFull,
  output logic        exEn,
  output logic [4:0]  exOp,
  output logic [31:0] exOperandO,
  output logic [31:0] exOperandT,
  output logic [4:0]  exTagW,
  output logic [4:0]  exNameW,
  output logic [31:0] exAddr
);

  localparam logic [4:0] TAG_FREE = 5'b11111;
  localparam logic [4:0] OP_NOP   = 5'd0;

  logic [7:0]  valid_reg;
  logic [4:0]  op_reg    [8];
  logic [31:0] opo_reg   [8];
  logic [31:0] opt_reg   [8];
  logic [4:0]  tago_reg  [8];
  logic [4:0]  tagt_reg  [8];
  logic [4:0]  tagw_reg  [8];
  logic [4:0]  namew_reg [8];
  logic [31:0] addr_reg  [8];

  logic [7:0] wake_o_alu, wake_o_ls, wake_t_alu, wake_t_ls, ready;
  logic [7:0] disp_sel, issue_sel;
  logic       disp_ok, sel_any;
  logic [2:0] sel_idx;
  logic [4:0]  new_tago, new_tagt;
  logic [31:0] new_opo, new_opt;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_entry
      assign wake_o_alu[gi] = valid_reg[gi] && cdbAluEn && (tago_reg[gi] == cdbAluTag) && (tago_reg[gi] != TAG_FREE);
      assign wake_o_ls[gi]  = valid_reg[gi] && cdbLsEn  && (tago_reg[gi] == cdbLsTag)  && (tago_reg[gi] != TAG_FREE);
      assign wake_t_alu[gi] = valid_reg[gi] && cdbAluEn && (tagt_reg[gi] == cdbAluTag) && (tagt_reg[gi] != TAG_FREE);
      assign wake_t_ls[gi]  = valid_reg[gi] && cdbLsEn  && (tagt_reg[gi] == cdbLsTag)  && (tagt_reg[gi] != TAG_FREE);
      assign ready[gi]      = valid_reg[gi] && (tago_reg[gi] == TAG_FREE) && (tagt_reg[gi] == TAG_FREE);
    end
  endgenerate

  always_comb begin
    new_tago = ALUtagO;
    new_opo  = ALUoperandO;
    new_tagt = ALUtagT;
    new_opt  = ALUoperandT;
`ifdef ALU_RS_BYPASS_EN
    if (ALUtagO != TAG_FREE && cdbAluEn && cdbAluTag == ALUtagO) begin
      new_tago = TAG_FREE;
      new_opo  = cdbAluData;
    end else if (ALUtagO != TAG_FREE && cdbLsEn && cdbLsTag == ALUtagO) begin
      new_tago = TAG_FREE;
      new_opo  = cdbLsData;
    end
    if (ALUtagT != TAG_FREE && cdbAluEn && cdbAluTag == ALUtagT) begin
      new_tagt = TAG_FREE;
      new_opt  = cdbAluData;
    end else if (ALUtagT != TAG_FREE && cdbLsEn && cdbLsTag == ALUtagT) begin
      new_tagt = TAG_FREE;
      new_opt  = cdbLsData;
    end
`endif
  end

  // Free-slot report and selection both scan downward so the lowest index wins.
  always_comb begin
    ALUfreeTag = 4'b1111;
    sel_any    = 1'b0;
    sel_idx    = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!valid_reg[i]) ALUfreeTag = 4'(i);
      if (ready[i]) begin
        sel_any = 1'b1;
        sel_idx = 3'(i);
      end
    end
  end

  assign rsFull    = &valid_reg;
  assign disp_ok   = ALUen && !rsFull && !ALUtagW[3] && !valid_reg[ALUtagW[2:0]];
  assign disp_sel  = disp_ok ? (8'd1 << ALUtagW[2:0]) : 8'd0;
  assign issue_sel = sel_any ? (8'd1 << sel_idx) : 8'd0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        valid_reg[i] <= 1'b0;
        op_reg[i]    <= OP_NOP;
        opo_reg[i]   <= 32'd0;
        opt_reg[i]   <= 32'd0;
        tago_reg[i]  <= TAG_FREE;
        tagt_reg[i]  <= TAG_FREE;
        tagw_reg[i]  <= TAG_FREE;
        namew_reg[i] <= 5'd0;
        addr_reg[i]  <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (disp_sel[i]) begin
          valid_reg[i] <= 1'b1;
          op_reg[i]    <= ALUop;
          opo_reg[i]   <= new_opo;
          opt_reg[i]   <= new_opt;
          tago_reg[i]  <= new_tago;
          tagt_reg[i]  <= new_tagt;
          tagw_reg[i]  <= ALUtagW;
          namew_reg[i] <= ALUnameW;
          addr_reg[i]  <= ALUaddr;
        end else begin
          if (issue_sel[i]) valid_reg[i] <= 1'b0;
          if (wake_o_alu[i]) begin
            tago_reg[i] <= TAG_FREE;
            opo_reg[i]  <= cdbAluData;
          end else if (wake_o_ls[i]) begin
            tago_reg[i] <= TAG_FREE;
            opo_reg[i]  <= cdbLsData;
          end
          if (wake_t_alu[i]) begin
            tagt_reg[i] <= TAG_FREE;
            opt_reg[i]  <= cdbAluData;
          end else if (wake_t_ls[i]) begin
            tagt_reg[i] <= TAG_FREE;
            opt_reg[i]  <= cdbLsData;
          end
        end
      end
    end
  end

  // Issue register: payload holds its last value when nothing is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exEn       <= 1'b0;
      exOp       <= OP_NOP;
      exOperandO <= 32'd0;
      exOperandT <= 32'd0;
      exTagW     <= TAG_FREE;
      exNameW    <= 5'd0;
      exAddr     <= 32'd0;
    end else begin
      exEn <= sel_any;
      if (sel_any) begin
        exOp       <= op_reg[sel_idx];
        exOperandO <= opo_reg[sel_idx];
        exOperandT <= opt_reg[sel_idx];
        exTagW     <= tagw_reg[sel_idx];
        exNameW    <= namew_reg[sel_idx];
        exAddr     <= addr_reg[sel_idx];
      end
    end
  end

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: a per-cycle vector table plus hand-built fill, bypass and reset sequences.
module tb_alu_rs;

  localparam logic [4:0] F = 5'b11111;

  logic        clk = 1'b0;
  logic        rst;
  logic        ALUen;
  logic [31:0] ALUoperandO, ALUoperandT, ALUaddr;
  logic [4:0]  ALUtagO, ALUtagT, ALUtagW, ALUnameW, ALUop;
  logic        cdbAluEn, cdbLsEn;
  logic [4:0]  cdbAluTag, cdbLsTag;
  logic [31:0] cdbAluData, cdbLsData;
  logic [3:0]  ALUfreeTag;
  logic        rsFull, exEn;
  logic [4:0]  exOp, exTagW, exNameW;
  logic [31:0] exOperandO, exOperandT, exAddr;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_rs dut (
    .clk(clk), .rst(rst), .ALUen(ALUen),
    .ALUoperandO(ALUoperandO), .ALUoperandT(ALUoperandT),
    .ALUtagO(ALUtagO), .ALUtagT(ALUtagT), .ALUtagW(ALUtagW),
    .ALUnameW(ALUnameW), .ALUop(ALUop), .ALUaddr(ALUaddr),
    .cdbAluEn(cdbAluEn), .cdbAluTag(cdbAluTag), .cdbAluData(cdbAluData),
    .cdbLsEn(cdbLsEn), .cdbLsTag(cdbLsTag), .cdbLsData(cdbLsData),
    .ALUfreeTag(ALUfreeTag), .rsFull(rsFull), .exEn(exEn), .exOp(exOp),
    .exOperandO(exOperandO), .exOperandT(exOperandT), .exTagW(exTagW),
    .exNameW(exNameW), .exAddr(exAddr)
  );

  typedef struct {
    logic        en;
    logic [4:0]  tagw, tago, tagt;
    logic [31:0] o, t;
    logic        ae;
    logic [4:0]  at;
    logic [31:0] ad;
    logic        le;
    logic [4:0]  lt;
    logic [31:0] ld;
    logic        xen;
    logic [4:0]  xw;
    logic [31:0] xo, xt;
    logic [3:0]  free;
    logic        full;
  } vec_t;

  function automatic vec_t mk(
      input logic en, input logic [4:0] tagw, input logic [4:0] tago, input logic [4:0] tagt,
      input logic [31:0] o, input logic [31:0] t,
      input logic ae, input logic [4:0] at, input logic [31:0] ad,
      input logic le, input logic [4:0] lt, input logic [31:0] ld,
      input logic xen, input logic [4:0] xw, input logic [31:0] xo, input logic [31:0] xt,
      input logic [3:0] free, input logic full);
    vec_t v;
    v.en = en; v.tagw = tagw; v.tago = tago; v.tagt = tagt; v.o = o; v.t = t;
    v.ae = ae; v.at = at; v.ad = ad; v.le = le; v.lt = lt; v.ld = ld;
    v.xen = xen; v.xw = xw; v.xo = xo; v.xt = xt; v.free = free; v.full = full;
    return v;
  endfunction

  // Idle cycle with expected outputs only.
  function automatic vec_t idle(input logic xen, input logic [4:0] xw, input logic [31:0] xo,
                                input logic [31:0] xt, input logic [3:0] free, input logic full);
    return mk(0, 0, F, F, 0, 0, 0, 0, 0, 0, 0, 0, xen, xw, xo, xt, free, full);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // op, name and address are derived from tagW so the issued payload is predictable.
  task automatic drive(input vec_t v);
    ALUen       = v.en;
    ALUtagW     = v.tagw;
    ALUtagO     = v.tago;
    ALUtagT     = v.tagt;
    ALUoperandO = v.o;
    ALUoperandT = v.t;
    ALUop       = v.tagw + 5'd1;
    ALUnameW    = v.tagw ^ 5'h0A;
    ALUaddr     = 32'h1000 + 32'(v.tagw) * 4;
    cdbAluEn    = v.ae;
    cdbAluTag   = v.at;
    cdbAluData  = v.ad;
    cdbLsEn     = v.le;
    cdbLsTag    = v.lt;
    cdbLsData   = v.ld;
  endtask

  task automatic check_vec(input vec_t v, input string nm);
    chk({nm, ".exEn"}, 32'(exEn), 32'(v.xen));
    chk({nm, ".freeTag"}, 32'(ALUfreeTag), 32'(v.free));
    chk({nm, ".rsFull"}, 32'(rsFull), 32'(v.full));
    if (v.xen) begin
      chk({nm, ".exTagW"}, 32'(exTagW), 32'(v.xw));
      chk({nm, ".exOperandO"}, exOperandO, v.xo);
      chk({nm, ".exOperandT"}, exOperandT, v.xt);
      chk({nm, ".exOp"}, 32'(exOp), 32'(v.xw + 5'd1));
      chk({nm, ".exNameW"}, 32'(exNameW), 32'(v.xw ^ 5'h0A));
      chk({nm, ".exAddr"}, exAddr, 32'h1000 + 32'(v.xw) * 4);
    end
    $display("[TB] %s: exEn=%0b tagW=%0d opO=%0h opT=%0h free=%0d full=%0b",
             nm, exEn, exTagW, exOperandO, exOperandT, ALUfreeTag, rsFull);
  endtask

  task automatic step(input vec_t v, input string nm);
    drive(v);
    @(posedge clk);
    #1;
    check_vec(v, nm);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".exEn"}, 32'(exEn), 32'd0);
    chk({nm, ".exOp"}, 32'(exOp), 32'd0);
    chk({nm, ".exOperandO"}, exOperandO, 32'd0);
    chk({nm, ".exOperandT"}, exOperandT, 32'd0);
    chk({nm, ".exTagW"}, 32'(exTagW), 32'(F));
    chk({nm, ".exNameW"}, 32'(exNameW), 32'd0);
    chk({nm, ".exAddr"}, exAddr, 32'd0);
    chk({nm, ".freeTag"}, 32'(ALUfreeTag), 32'd0);
    chk({nm, ".rsFull"}, 32'(rsFull), 32'd0);
    $display("[TB] %s: reset values sampled", nm);
  endtask

  vec_t vecs[22];

  initial begin
    vecs[0]  = mk(1, 0, F, F, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = idle(1, 0, 3, 4, 0, 0);
    vecs[2]  = idle(0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 5'h12, F, 0, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = idle(0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, F, F, 0, 0, 0, 0, 0, 1, 5'h12, 32'hDEAD, 0, 0, 0, 0, 0, 0);
    vecs[6]  = idle(1, 1, 32'hDEAD, 9, 0, 0);
    vecs[7]  = idle(0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 2, 5'h03, F, 0, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9]  = mk(1, 5, F, 5'h11, 50, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(0, 0, F, F, 0, 0, 1, 5'h03, 32'h20, 1, 5'h11, 32'h51, 0, 0, 0, 0, 0, 0);
    vecs[11] = idle(1, 2, 32'h20, 22, 0, 0);
    vecs[12] = idle(1, 5, 50, 32'h51, 0, 0);
    vecs[13] = idle(0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 3, 5'h06, 5'h17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(0, 0, F, F, 0, 0, 1, 5'h06, 32'hA, 1, 5'h17, 32'hB, 0, 0, 0, 0, 0, 0);
    vecs[16] = idle(1, 3, 32'hA, 32'hB, 0, 0);
    vecs[17] = idle(0, 0, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, F, F, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    vecs[19] = mk(1, 1, F, F, 5, 6, 0, 0, 0, 0, 0, 0, 1, 0, 1, 2, 0, 0);
    vecs[20] = idle(1, 1, 5, 6, 0, 0);
    vecs[21] = idle(0, 0, 0, 0, 0, 0);

    drive(idle(0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    #12;
    chk_reset_vals("reset");
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 22; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Fill with unready entries; a re-dispatch to a valid slot must be ignored.
    for (int i = 0; i < 7; i++)
      step(mk(1, 5'(i), 5'h10, F, 0, 32'(i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'(i + 1), 0),
           $sformatf("fill%0d", i));
    step(mk(1, 2, F, F, 32'h77, 32'h77, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0), "dup_disp");
    step(idle(0, 0, 0, 0, 7, 0), "dup_idle");
    step(mk(1, 7, 5'h10, F, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1), "fill7");
    step(mk(1, 3, F, F, 32'h99, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 1), "full_disp");
    step(idle(0, 0, 0, 0, 4'hF, 1), "full_idle");
    step(mk(0, 0, F, F, 0, 0, 0, 0, 0, 1, 5'h10, 32'hBEEF, 0, 0, 0, 0, 4'hF, 1), "wake_all");
    for (int i = 0; i < 8; i++)
      step(idle(1, 5'(i), 32'hBEEF, 32'(i), 0, 0), $sformatf("drain%0d", i));
    step(idle(0, 0, 0, 0, 0, 0), "drain_end");

    // Dispatch coinciding with its producer's broadcast.
    step(mk(1, 4, 5'h05, F, 0, 1, 1, 5'h05, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0), "byp_disp");
`ifdef ALU_RS_BYPASS_EN
    step(idle(1, 4, 7, 1, 0, 0), "byp_issue");
    step(idle(0, 0, 0, 0, 0, 0), "byp_after");
`else
    for (int i = 0; i < 4; i++) step(idle(0, 0, 0, 0, 0, 0), $sformatf("byp_none%0d", i));
`endif

    // Reset while entries are pending and an issue is in flight.
    step(mk(1, 0, F, F, 10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "pre0");
    step(mk(1, 1, F, F, 11, 1, 0, 0, 0, 0, 0, 0, 1, 0, 10, 0, 0, 0), "pre1");
    step(mk(1, 2, 5'h10, F, 12, 2, 0, 0, 0, 0, 0, 0, 1, 1, 11, 1, 0, 0), "pre2");
    drive(idle(0, 0, 0, 0, 0, 0));
    #2 rst = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst.exEn", 32'(exEn), 32'd0);
    for (int i = 0; i < 3; i++) step(idle(0, 0, 0, 0, 0, 0), $sformatf("post_rst%0d", i));
    step(mk(1, 0, F, F, 32'h33, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "rel_disp");
    step(idle(1, 0, 32'h33, 32'h44, 0, 0), "rel_issue");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 ALUen  in  1  dispatch valid.
REQ-004 ALUoperandO, ALUoperandT  in  32 each  operand data; meaningful only when the matching tag equals tagFree.
REQ-005 ALUtagO, ALUtagT  in  5 each  source tags; tagFree (5'b11111) means the data is ready.
REQ-006 ALUtagW  in  5  destination tag; bit 4 is the ALU prefix (0); bits [3:0] are the entry index, 0..7.
REQ-007 ALUnameW  in  5  destination register name.
REQ-008 ALUop  in  5  opcode.
REQ-009 ALUaddr  in  32  instruction address.
REQ-010 cdbAluEn, cdbAluTag, cdbAluData  in  1/5/32  ALU result broadcast.
REQ-011 cdbLsEn, cdbLsTag, cdbLsData  in  1/5/32  load result broadcast.
REQ-012 ALUfreeTag  out  4  lowest free entry index; 4'b1111 when full.
REQ-013 rsFull  out  1  no free entry.
REQ-014 exEn  out  1  issue valid, registered.
REQ-015 exOp, exOperandO, exOperandT, exTagW, exNameW, exAddr  out  5/32/32/5/5/32  issued entry fields, registered.

Function
REQ-016 Eight entries; each holds valid, op, two operands, two tags, tagW, nameW, addr.
REQ-017 On dispatch with ALUen=1 at edge T, write entry ALUtagW[3:0] and set it valid; the entry is visible from cycle T+1.
REQ-018 Dispatch to an already-valid entry, or while rsFull=1, is ignored with no state change.
REQ-019 ALUfreeTag and rsFull are combinational from the current valid bits only.
REQ-020 Wakeup: for each valid entry, any source tag equal to an enabled CDB tag captures the CDB data and becomes tagFree at the edge.
REQ-021 Both CDBs may match in the same cycle, on different operands or on both operands of one entry.
REQ-022 An entry is ready when valid and both tags equal tagFree.
REQ-023 Select, each cycle, the lowest-index ready entry, evaluated from registered state (wakeups this cycle are not visible).
REQ-024 At the edge, load the selected entry into the ex* registers, set exEn=1, and clear its valid bit.
REQ-025 With no ready entry, exEn=0 at the next edge and the other ex* outputs hold their last values.
REQ-026 Minimum latency: dispatch of ready operands in cycle 0 gives exEn=1 in cycle 2.
REQ-027 A CDB match in cycle N makes the entry selectable in cycle N+1, giving exEn in N+2.
REQ-028 An entry freed by issue at edge T is reported free from cycle T+1.
REQ-029 Simultaneous issue of entry i and dispatch to entry j!=i are both performed.
REQ-030 The exTagW output is the issued entry's tagW unchanged.

Reset
REQ-031 rst low asynchronously clears all valid bits.
REQ-032 During reset: exEn=0; exOp=NOP; exOperandO=exOperandT=0; exTagW=tagFree; exNameW=0; exAddr=0; ALUfreeTag=0; rsFull=0.
REQ-033 Reset asserted mid-operation discards all entries and any pending issue; the first dispatch is accepted at the first edge after rst rises.

Configuration
REQ-034 The macro ALU_RS_BYPASS_EN controls same-cycle dispatch bypass.
REQ-035 With ALU_RS_BYPASS_EN defined: a dispatching source tag that matches an enabled CDB tag in the same cycle is stored as tagFree with the CDB data.
REQ-036 Without ALU_RS_BYPASS_EN: the tag is stored as given, and the dispatcher must not dispatch a tag being broadcast that cycle.

Verification
REQ-037 Reset; dispatch ADD with operands 3 and 4, tags free, tagW=5'b00000 in cycle 0 -> cycle 2: exEn=1, exOperandO=3, exOperandT=4, exTagW=0; cycle 3: ALUfreeTag=0.
REQ-038 Dispatch with ALUtagO=5'b10010 (LS tag) -> cdbLsEn with tag 5'b10010, data 0xDEAD in cycle 3 -> exEn=1 in cycle 5 with exOperandO=0xDEAD.
REQ-039 Fill all 8 entries with unready tags -> rsFull=1, ALUfreeTag=4'b1111; a further dispatch leaves state unchanged.
REQ-040 Entries 2 and 5 become ready in the same cycle -> entry 2 issues first, entry 5 issues the next cycle.
REQ-041 Bypass, macro defined: dispatch in the same cycle as a matching cdbAluEn with data 7 -> issue two cycles later with operand 7.
REQ-042 Bypass, macro undefined: same stimulus -> the entry never issues.
REQ-043 Drop rst while 3 entries are valid -> all outputs take their reset values immediately; no issue occurs after release.
